// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV64M multiply/divide unit.
// Contents: default operand width, funct3 operation codes, FSM state encoding
// and a small decode helper.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  // Every divide/remainder encoding has funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative datapath, one bit per step.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : load operands and set the counter to XLEN-1
//   step_i      : perform one iteration and decrement the counter
//   is_div_i    : operation class captured at load (1 = divide)
//   a_i, b_i    : unsigned multiplicand/dividend and multiplier/divisor
//   last_o      : counter is zero, the current step is the final one
//   hi_o, lo_o  : multiply -> product {hi,lo}; divide -> hi = remainder, lo = quotient
import muldiv_pkg::*;

module muldiv_core #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic [XLEN:0]   add_sum, shifted, diff;

  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    // Restoring division: bring the next dividend bit into the partial remainder.
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = is_div_i ? a_i : b_i;
      opnd_d = is_div_i ? b_i : a_i;
      cnt_d  = CW'(XLEN - 1);
      div_d  = is_div_i;
    end else if (step_i) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        if (shifted >= {1'b0, opnd_q}) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        // Multiplier bits are consumed from the bottom of lo while the
        // product grows in from the top; the adder carry is kept.
        {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  assign last_o = (cnt_q == '0);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit driving the register file
// write port directly.
//   clk, reset       : clock, synchronous active-high reset
//   start            : request, accepted only in IDLE
//   funct3           : M-extension operation
//   operandA/B       : rs1/rs2 values, needed only at the accepting edge
//   destRegister     : rd index
//   busy             : unit occupied (cycle after acceptance through DONE)
//   done             : one-cycle completion pulse
//   regWrite         : write enable, done qualified by rd != 0
//   writeRegister    : rd of the completed operation
//   writeData        : result
//   dbg_state_o      : current FSM state
// Handshake: start is a single-cycle request with no ready; it is accepted
// exactly when the unit is in IDLE (busy low) and ignored otherwise.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [4:0]      destRegister,
  output logic            busy,
  output logic            done,
  output logic            regWrite,
  output logic [4:0]      writeRegister,
  output logic [XLEN-1:0] writeData,
  output logic [2:0]      dbg_state_o
);

  muldiv_state_e   state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, spec_res_q, spec_res_d, wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d, wreg_q, wreg_d;
  logic            neg_main_q, neg_main_d, neg_rem_q, neg_rem_d;
  logic            special_q, special_d, spec_wait_q, spec_wait_d;

  logic            sa, sb, div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, quo, rem, result;
  logic [2*XLEN-1:0] prod;
  logic            core_load, core_step, core_last;
  logic [XLEN-1:0] core_hi, core_lo;

  // Sign and special-case decode, evaluated from the latched request in PREP.
  always_comb begin
    sa = a_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU) |
                        (op_q == OP_DIV) | (op_q == OP_REM));
    sb = b_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM));
    abs_a    = sa ? -a_q : a_q;
    abs_b    = sb ? -b_q : b_q;
    div_zero = op_is_div(op_q) & (b_q == '0);
    overflow = op_is_div(op_q) & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) &
               (b_q == '1);
    special  = div_zero | overflow;
    // op_q[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
    if (div_zero) spec_res = op_q[1] ? a_q : '1;
    else          spec_res = op_q[1] ? '0 : a_q;
  end

  // Result fix-up: the product is negated as a whole so the high half
  // carries the borrow from the low half correctly.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_main_q) prod = -prod;
    quo = neg_main_q ? -core_lo : core_lo;
    rem = neg_rem_q  ? -core_hi : core_hi;
    if (special_q)               result = spec_res_q;
    else if (op_q == OP_MUL)     result = prod[XLEN-1:0];
    else if (!op_is_div(op_q))   result = prod[2*XLEN-1:XLEN];
    else if (op_q[1])            result = rem;
    else                         result = quo;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    neg_main_d  = neg_main_q;
    neg_rem_d   = neg_rem_q;
    special_d   = special_q;
    spec_res_d  = spec_res_q;
    spec_wait_d = spec_wait_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        op_d    = funct3;
        a_d     = operandA;
        b_d     = operandB;
        rd_d    = destRegister;
        state_d = ST_PREP;
      end
      ST_PREP: begin
        neg_main_d  = sa ^ sb;
        neg_rem_d   = sa;
        special_d   = special;
        spec_res_d  = spec_res;
        spec_wait_d = special;
        core_load   = ~special;
        state_d     = special ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Special cases hold FIX one extra cycle so their writeback lands
        // a fixed three edges after acceptance.
        if (spec_wait_q) begin
          spec_wait_d = 1'b0;
        end else begin
          wdata_d = result;
          wreg_d  = rd_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      spec_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      neg_main_q  <= neg_main_d;
      neg_rem_q   <= neg_rem_d;
      special_q   <= special_d;
      spec_res_q  <= spec_res_d;
      spec_wait_q <= spec_wait_d;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (op_is_div(op_q)),
    .a_i      (abs_a),
    .b_i      (abs_b),
    .last_o   (core_last),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign regWrite      = (state_q == ST_DONE) && (wreg_q != 5'd0);
  assign writeRegister = wreg_q;
  assign writeData     = wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with an expected-result queue.
module tb_muldiv_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operandA, operandB;
  logic [4:0]      destRegister;
  logic            busy, done, regWrite;
  logic [4:0]      writeRegister;
  logic [XLEN-1:0] writeData;
  logic [2:0]      dbg_state;

  logic [XLEN-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .funct3        (funct3),
    .operandA      (operandA),
    .operandB      (operandB),
    .destRegister  (destRegister),
    .busy          (busy),
    .done          (done),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .dbg_state_o   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, expect its result from the queue after lat edges.
  // When poke is set, start is re-asserted mid-CALC with other operands.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int lat, input bit poke);
    int k;
    bit got;
    int extra;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; funct3 = f; operandA = a; operandB = b; destRegister = rd;
    @(posedge clk); #1;
    start = 1'b0;
    operandA = {$urandom, $urandom};
    operandB = {$urandom, $urandom};
    destRegister = 5'($urandom_range(0, 31));
    k = 0; got = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk);
      start = (poke && k == 9);
      if (start) begin funct3 = 3'b000; operandA = 64'd99; operandB = 64'd99; end
      @(posedge clk); k++; #1;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(k), 64'(lat));
      check({tag, "_data"}, writeData, exp_q.pop_front());
      check({tag, "_wreg"}, 64'(writeRegister), 64'(rd));
      check({tag, "_regwrite"}, 64'(regWrite), 64'(rd != 5'd0));
      check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_done_after"}, 64'(done), 64'd0);
      check({tag, "_data_hold"}, writeData, exp);
    end else begin
      void'(exp_q.pop_front());
    end
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_extra_done"}, 64'(extra), 64'd0);
    end
  endtask

  logic [63:0]  ra, rb;
  logic [127:0] wide;
  int           k2, stray;

  initial begin
    reset = 1'b1; start = 1'b1; funct3 = 3'b000;
    operandA = 64'd3; operandB = 64'd4; destRegister = 5'd1;
    @(posedge clk); #1;
    // Reset wins over a simultaneous start.
    check("rst_override_busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_regwrite", 64'(regWrite), 64'd0);
    check("rst_wreg", 64'(writeRegister), 64'd0);
    check("rst_wdata", writeData, 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op("mul_7x6",     3'b000, 64'd7, 64'd6, 5'd5, 64'd42, 66, 1'b0);
    run_op("mulh_m1x2",   3'b001, ONES, 64'd2, 5'd6, ONES, 66, 1'b0);
    run_op("mulhu_m1x2",  3'b011, ONES, 64'd2, 5'd7, 64'd1, 66, 1'b0);
    run_op("mulhsu_m1x2", 3'b010, ONES, 64'd2, 5'd8, ONES, 66, 1'b0);
    run_op("div_m7_2",    3'b100, -64'sd7, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
    run_op("rem_m7_2",    3'b110, -64'sd7, 64'd2, 5'd10, ONES, 66, 1'b0);
    run_op("divu_100_7",  3'b101, 64'd100, 64'd7, 5'd11, 64'd14, 66, 1'b0);
    run_op("remu_100_7",  3'b111, 64'd100, 64'd7, 5'd12, 64'd2, 66, 1'b0);
    run_op("divu_by0",    3'b101, 64'd5, 64'd0, 5'd13, ONES, 3, 1'b0);
    run_op("rem_by0",     3'b110, 64'd5, 64'd0, 5'd14, 64'd5, 3, 1'b0);
    run_op("div_ovf",     3'b100, MINV, ONES, 5'd15, MINV, 3, 1'b0);
    run_op("rem_ovf",     3'b110, MINV, ONES, 5'd16, 64'd0, 3, 1'b0);
    run_op("mul_rd0",     3'b000, 64'd3, 64'd3, 5'd0, 64'd9, 66, 1'b0);
    run_op("mul_restart", 3'b000, 64'd1234, 64'd5678, 5'd17, 64'd7006652, 66, 1'b1);
    run_op("mul_zero",    3'b000, 64'd0, 64'd12345, 5'd18, 64'd0, 66, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      wide = {64'd0, ra} * {64'd0, rb};
      run_op("mulhu_rand", 3'b011, ra, rb, 5'($urandom_range(1, 31)), wide[127:64], 66, 1'b0);
      rb = {32'd0, $urandom} | 64'd1;
      run_op("divu_rand", 3'b101, ra, rb, 5'($urandom_range(1, 31)), ra / rb, 66, 1'b0);
      run_op("remu_rand", 3'b111, ra, rb, 5'($urandom_range(1, 31)), ra % rb, 66, 1'b0);
    end

    // Reset at edge N+30 of a DIV: state and outputs clear, nothing is written.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; operandA = 64'd1000; operandB = 64'd3; destRegister = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (k2 = 1; k2 < 30; k2++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_regwrite", 64'(regWrite), 64'd0);
    check("midrst_wdata", writeData, 64'd0);
    @(negedge clk); reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done) stray++;
    end
    check("midrst_no_pulse", 64'(stray), 64'd0);
    run_op("mul_after_rst", 3'b000, 64'd7, 64'd6, 5'd3, 64'd42, 66, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
